load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the ALU.
- Takes ALUResult as the effective address and WriteData as store data, then runs one load or store per instruction to data memory over a valid/ready request channel and a valid-only response channel.
- Stalls the pipeline while the access is outstanding.
- Returns loads byte/halfword-aligned and sign- or zero-extended, ready for writeback.

Parameters:
- DATA_WIDTH, 32: data and address width. Only 32 is supported.
- FUNCT3_WIDTH, 3: width of the size/sign field.
- BE_WIDTH, 4: number of byte enables (DATA_WIDTH/8).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemReq  in  1  execute stage presents a load or store this cycle.
- MemWrite  in  1  1 = store, 0 = load.
- Funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResult  in  32  effective byte address.
- WriteData  in  32  store data, right-justified.
- DMemValid  out  1  memory request valid.
- DMemReady  in  1  memory accepts the request.
- DMemAddr  out  32  word-aligned address ({addr[31:2],2'b00}).
- DMemWE  out  1  write enable.
- DMemByteEn  out  4  byte lanes written.
- DMemWData  out  32  lane-replicated store data.
- DMemRValid  in  1  read response valid.
- DMemRData  in  32  read response word.
- Stall  out  1  freeze upstream stages.
- LsuDone  out  1  one-cycle completion pulse.
- ReadData  out  32  formatted load result.
- Fault  out  1  one-cycle pulse: misaligned access or illegal Funct3.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - DMemValid, DMemWE, DMemByteEn, DMemAddr, DMemWData, LsuDone, Fault, ReadData all 0.
  - Captured request registers cleared.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, MemReq=1, legal and aligned:
  - Capture address, write flag, Funct3 and WriteData.
  - Go to REQ.
  - Stall=1 combinationally this cycle.
- IDLE, MemReq=1, illegal or misaligned:
  - Fault=1 for that cycle, no memory request, stay in IDLE, Stall=0.
  - Misaligned means: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Illegal means: Funct3 011, 110, 111; or a store with Funct3 100 or 101.
- REQ:
  - DMemValid=1. Addr, WE, ByteEn and WData stay stable until DMemValid&DMemReady.
  - On handshake: store goes to DONE, load goes to WAIT.
  - Stall=1.
- WAIT:
  - Stall=1.
  - On DMemRValid: register the formatted data into ReadData, go to DONE.
  - DMemRValid is ignored in every state other than WAIT. A same-cycle response during REQ is not supported; memory responds at least 1 cycle after the handshake.
- DONE:
  - LsuDone=1 and Stall=0 for exactly one cycle, then go to IDLE.
  - MemReq is ignored in DONE. The pipeline advances on this cycle, so the next request is sampled in IDLE.
- Minimum latency, MemReq to LsuDone:
  - Store: 3 cycles.
  - Load: 4 cycles (ready immediately, response 1 cycle after handshake).
- Store formatting (o = addr[1:0]):
  - SB: ByteEn = 0001<<o, WData = byte replicated x4.
  - SH: ByteEn = 0011<<o, WData = halfword replicated x2.
  - SW: ByteEn = 1111, WData = WriteData.
- Load formatting:
  - Shift DMemRData right by 8*o.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- ReadData holds its value until the next load completes. Stores leave it unchanged.
- Outputs not defined in the current state are driven to 0.
- Reset mid-operation: return to IDLE at once. A late DMemRValid after reset is ignored because the FSM is in IDLE.

Decomposition:
- Package lsu_pkg holds:
  - the state enum (IDLE, REQ, WAIT, DONE);
  - Funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - byte-enable and alignment-check functions.
- One combinational sub-module, lsu_load_align: inputs are the response word, offset and Funct3; output is the extended result. Reused by a future cache.

Test Plan:
- SW: addr 0x100, data 0xDEADBEEF, DMemReady=1 -> DMemAddr=0x100, ByteEn=1111, WE=1, LsuDone in cycle 3.
- SB: addr 0x203, data 0x000000A5 -> DMemAddr=0x200, ByteEn=1000, WData=0xA5A5A5A5.
- LB: addr 0x301, memory returns 0x0000_80FF -> ReadData=0xFFFFFF80. Same access as LBU -> 0x00000080.
- LH: addr 0x102, DMemReady held low 5 cycles, RValid 3 cycles after handshake, RData=0x7FFF0000 -> request fields stable throughout, Stall=1 until DONE, ReadData=0x00007FFF.
- LW at 0x102 -> Fault pulse, DMemValid never asserted. Funct3=011 -> Fault. SH at 0x101 -> Fault.
- rst_n low during WAIT, then stray DMemRValid -> FSM in IDLE, all outputs 0, ReadData unchanged at 0, no LsuDone.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared state codes, Funct3 codes and request-formatting
//               helpers for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned sizes only make sense for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3)
            F3_H, F3_HU: ok = ~off[0];
            F3_W:        ok = (off == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{wd[7:0]}};
            F3_H:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Lane-shifts a memory read word and sign/zero-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_offset,
    input  logic [2:0]            i_funct3,
    output logic [DATA_WIDTH-1:0] o_result
);

    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_result = w_shifted;
        case (i_funct3)
            F3_B:    o_result = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_result = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   o_result = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
            F3_HU:   o_result = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
            default: o_result = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-stage LSU: one load/store per instruction over a
//               valid/ready request and valid-only response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNCT3_WIDTH = 3,
    parameter int BE_WIDTH     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    MemReq,
    input  logic                    MemWrite,
    input  logic [FUNCT3_WIDTH-1:0] Funct3,
    input  logic [DATA_WIDTH-1:0]   ALUResult,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    output logic                    DMemValid,
    input  logic                    DMemReady,
    output logic [DATA_WIDTH-1:0]   DMemAddr,
    output logic                    DMemWE,
    output logic [BE_WIDTH-1:0]     DMemByteEn,
    output logic [DATA_WIDTH-1:0]   DMemWData,
    input  logic                    DMemRValid,
    input  logic [DATA_WIDTH-1:0]   DMemRData,
    output logic                    Stall,
    output logic                    LsuDone,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    Fault
);

    logic [1:0]            r_state;
    logic [1:0]            r_offset;
    logic                  r_we;
    logic [2:0]            r_f3;
    logic                  r_dmem_valid;
    logic [DATA_WIDTH-1:0] r_dmem_addr;
    logic                  r_dmem_we;
    logic [BE_WIDTH-1:0]   r_dmem_be;
    logic [DATA_WIDTH-1:0] r_dmem_wdata;
    logic                  r_lsu_done;
    logic [DATA_WIDTH-1:0] r_read_data;

    logic                  w_idle;
    logic                  w_req_ok;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_load_result;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_req_ok = f3_legal(Funct3, MemWrite) && f3_aligned(Funct3, ALUResult[1:0]);
    assign w_accept = w_idle && MemReq && w_req_ok;

    lsu_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .i_rdata  (DMemRData),
        .i_offset (r_offset),
        .i_funct3 (r_f3),
        .o_result (w_load_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_offset     <= '0;
            r_we         <= 1'b0;
            r_f3         <= '0;
            r_dmem_valid <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_we    <= 1'b0;
            r_dmem_be    <= '0;
            r_dmem_wdata <= '0;
            r_lsu_done   <= 1'b0;
            r_read_data  <= '0;
        end else begin
            r_lsu_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_offset     <= ALUResult[1:0];
                        r_we         <= MemWrite;
                        r_f3         <= Funct3;
                        r_dmem_valid <= 1'b1;
                        r_dmem_addr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        r_dmem_we    <= MemWrite;
                        // Loads carry no lane enables or data on the request.
                        r_dmem_be    <= MemWrite ? byte_en(Funct3, ALUResult[1:0]) : '0;
                        r_dmem_wdata <= MemWrite ? store_data(Funct3, WriteData) : '0;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (DMemReady) begin
                        r_dmem_valid <= 1'b0;
                        r_dmem_addr  <= '0;
                        r_dmem_we    <= 1'b0;
                        r_dmem_be    <= '0;
                        r_dmem_wdata <= '0;
                        if (r_we) begin
                            r_lsu_done <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (DMemRValid) begin
                        r_read_data <= w_load_result;
                        r_lsu_done  <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign DMemValid  = r_dmem_valid;
    assign DMemAddr   = r_dmem_addr;
    assign DMemWE     = r_dmem_we;
    assign DMemByteEn = r_dmem_be;
    assign DMemWData  = r_dmem_wdata;
    assign LsuDone    = r_lsu_done;
    assign ReadData   = r_read_data;
    assign Fault      = w_idle && MemReq && !w_req_ok;
    assign Stall      = w_accept || (r_state == ST_REQ) || (r_state == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed, table-driven bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        MemReq;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        DMemValid;
    logic        DMemReady;
    logic [31:0] DMemAddr;
    logic        DMemWE;
    logic [3:0]  DMemByteEn;
    logic [31:0] DMemWData;
    logic        DMemRValid;
    logic [31:0] DMemRData;
    logic        Stall;
    logic        LsuDone;
    logic [31:0] ReadData;
    logic        Fault;

    int          n_tests;
    int          n_fail;
    logic [31:0] last_rd;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdly;
        int          vdly;
        logic        fault;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    load_store_unit #(
        .DATA_WIDTH   (32),
        .FUNCT3_WIDTH (3),
        .BE_WIDTH     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReq     (MemReq),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .DMemValid  (DMemValid),
        .DMemReady  (DMemReady),
        .DMemAddr   (DMemAddr),
        .DMemWE     (DMemWE),
        .DMemByteEn (DMemByteEn),
        .DMemWData  (DMemWData),
        .DMemRValid (DMemRValid),
        .DMemRData  (DMemRData),
        .Stall      (Stall),
        .LsuDone    (LsuDone),
        .ReadData   (ReadData),
        .Fault      (Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int rdly, input int vdly, input logic fault,
                                input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic [31:0] e_rd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.rdly = rdly; v.vdly = vdly; v.fault = fault;
        v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        MemReq = 1'b1; MemWrite = v.we; Funct3 = v.f3; ALUResult = v.addr; WriteData = v.wdata;
        #1;
        if (v.fault) begin
            chk("fault_pulse", {31'd0, Fault}, 32'd1);
            chk("fault_stall", {31'd0, Stall}, 32'd0);
            chk("fault_valid", {31'd0, DMemValid}, 32'd0);
            @(negedge clk);
            MemReq = 1'b0;
            #1;
            chk("fault_clear", {31'd0, Fault}, 32'd0);
            chk("fault_noreq", {31'd0, DMemValid}, 32'd0);
            chk("fault_rd", ReadData, last_rd);
            return;
        end
        chk("accept_stall", {31'd0, Stall}, 32'd1);
        chk("accept_fault", {31'd0, Fault}, 32'd0);
        @(negedge clk);
        MemReq = 1'b0; ALUResult = 32'h0; WriteData = 32'h0; Funct3 = 3'b000; MemWrite = 1'b0;
        for (int k = 0; k <= v.rdly; k++) begin
            DMemReady = (k == v.rdly);
            #1;
            chk("req_valid", {31'd0, DMemValid}, 32'd1);
            chk("req_addr", DMemAddr, v.e_addr);
            chk("req_we", {31'd0, DMemWE}, {31'd0, v.we});
            if (v.we) begin
                chk("req_be", {28'd0, DMemByteEn}, {28'd0, v.e_be});
                chk("req_wdata", DMemWData, v.e_wdata);
            end
            chk("req_stall", {31'd0, Stall}, 32'd1);
            chk("req_nodone", {31'd0, LsuDone}, 32'd0);
            @(negedge clk);
        end
        DMemReady = 1'b0;
        if (!v.we) begin
            for (int k = 1; k <= v.vdly; k++) begin
                #1;
                chk("wait_stall", {31'd0, Stall}, 32'd1);
                chk("wait_valid", {31'd0, DMemValid}, 32'd0);
                chk("wait_nodone", {31'd0, LsuDone}, 32'd0);
                if (k == v.vdly) begin
                    DMemRValid = 1'b1;
                    DMemRData  = v.rdata;
                end
                @(negedge clk);
            end
            DMemRValid = 1'b0;
            DMemRData  = 32'h0;
            last_rd    = v.e_rd;
        end
        #1;
        chk("done_pulse", {31'd0, LsuDone}, 32'd1);
        chk("done_stall", {31'd0, Stall}, 32'd0);
        chk("done_valid", {31'd0, DMemValid}, 32'd0);
        chk("done_rdata", ReadData, last_rd);
        @(negedge clk);
        #1;
        chk("done_once", {31'd0, LsuDone}, 32'd0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; last_rd = 32'h0;
        rst_n = 1'b0; MemReq = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        ALUResult = 32'h0; WriteData = 32'h0; DMemReady = 1'b0;
        DMemRValid = 1'b0; DMemRData = 32'h0;

        //            we  f3    addr          wdata         rdata         rd vd flt e_addr        be       e_wdata       e_rd
        vecs.push_back(mk(1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0, 0, 0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0));
        vecs.push_back(mk(1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0,         0, 0, 0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h0000_0301, 32'h0,         32'h0000_80FF, 0, 1, 0, 32'h0000_0300, 4'b0000, 32'h0,         32'hFFFF_FF80));
        vecs.push_back(mk(0, 3'b100, 32'h0000_0301, 32'h0,         32'h0000_80FF, 0, 1, 0, 32'h0000_0300, 4'b0000, 32'h0,         32'h0000_0080));
        vecs.push_back(mk(1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0,         0, 0, 0, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0102, 32'h0,         32'h7FFF_0000, 5, 3, 0, 32'h0000_0100, 4'b0000, 32'h0,         32'h0000_7FFF));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0100, 32'h0,         32'h1234_F00D, 0, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,         32'hFFFF_F00D));
        vecs.push_back(mk(0, 3'b101, 32'h0000_0100, 32'h0,         32'h1234_F00D, 0, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,         32'h0000_F00D));
        vecs.push_back(mk(1, 3'b000, 32'h0000_0201, 32'h0000_005A, 32'h0,         1, 0, 0, 32'h0000_0200, 4'b0010, 32'h5A5A_5A5A, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 2, 2, 0, 32'h0000_0104, 4'b0000, 32'h0,         32'hCAFE_F00D));
        vecs.push_back(mk(0, 3'b000, 32'h0000_0302, 32'h0,         32'h007F_0000, 0, 1, 0, 32'h0000_0300, 4'b0000, 32'h0,         32'h0000_007F));
        vecs.push_back(mk(0, 3'b010, 32'h0000_0102, 32'h0,         32'h0,         0, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h0000_0101, 32'h0,         32'h0,         0, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(1, 3'b100, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(0, 3'b101, 32'h0000_0103, 32'h0,         32'h0,         0, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(1, 3'b111, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 1, 32'h0,         4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h0000_0108, 32'h1122_3344, 32'h0,         0, 0, 0, 32'h0000_0108, 4'b1111, 32'h1122_3344, 32'h0));

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", {31'd0, DMemValid}, 32'd0);
        chk("rst_addr", DMemAddr, 32'h0);
        chk("rst_we_be", {27'd0, DMemWE, DMemByteEn}, 32'd0);
        chk("rst_wdata", DMemWData, 32'h0);
        chk("rst_done_fault_stall", {29'd0, LsuDone, Fault, Stall}, 32'd0);
        chk("rst_rdata", ReadData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // A response arriving while idle must be ignored.
        @(negedge clk);
        DMemRValid = 1'b1; DMemRData = 32'h5555_5555;
        @(negedge clk);
        DMemRValid = 1'b0; DMemRData = 32'h0;
        #1;
        chk("idle_rvalid_done", {31'd0, LsuDone}, 32'd0);
        chk("idle_rvalid_rdata", ReadData, 32'h0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Reset while a load is waiting for its response.
        @(negedge clk);
        MemReq = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h0000_0040;
        @(negedge clk);
        MemReq = 1'b0; DMemReady = 1'b1;
        @(negedge clk);
        DMemReady = 1'b0;
        #1;
        chk("midrst_in_wait", {31'd0, Stall}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, DMemValid}, 32'd0);
        chk("midrst_addr", DMemAddr, 32'h0);
        chk("midrst_stall_done", {30'd0, Stall, LsuDone}, 32'd0);
        chk("midrst_rdata", ReadData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        DMemRValid = 1'b1; DMemRData = 32'hFFFF_FFFF;
        @(negedge clk);
        DMemRValid = 1'b0; DMemRData = 32'h0;
        #1;
        chk("stray_done", {31'd0, LsuDone}, 32'd0);
        chk("stray_stall", {31'd0, Stall}, 32'd0);
        chk("stray_rdata", ReadData, 32'h0);
        chk("stray_valid", {31'd0, DMemValid}, 32'd0);
        @(negedge clk);
        #1;
        chk("stray_done_later", {31'd0, LsuDone}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
